mux_select_sequencer: RTL and testbench

Select-line generator and sample collector that sits directly upstream of the lab's 4:1 multiplexer. It drives the mux select pair `s1`/`s0` and reads the mux output `m` back. It steps the selection either automatically from a prescaled tick or manually from a debounced push-button, and records the value of `m` for each of the four channels. After every complete sweep it presents a 4-bit snapshot with a one-cycle valid pulse, so the board LEDs show all four mux inputs as seen through the mux.

---
 rtl/mux_select_sequencer.sv | 88 ++++++++
 tb/tb_mux_select_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/mux_select_sequencer.sv
// Drives the 4:1 mux select lines, stepping automatically from a prescaled tick or
// manually from a debounced button, and collects one sample of m per channel.
module mux_select_sequencer #(
   parameter int SCAN_DIV   = 25000000,
   parameter int DEB_CYCLES = 500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   input  logic       auto,
   input  logic       m,
   output logic       s1,
   output logic       s0,
   output logic [3:0] sample,
   output logic       sweep_done
);

   localparam int SCAN_W = $clog2(SCAN_DIV);
   localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);

   logic              step_meta, step_s;
   logic              auto_meta, auto_s;
   logic [DEB_W-1:0]  deb_cnt;
   logic              step_d, step_d_q;
   logic [SCAN_W-1:0] pre_cnt;
   logic [1:0]        sel;
   logic              tick, step_evt, adv;

   // tick is gated by auto_s so a stale count in the cycle after leaving auto mode
   // can never advance the selection.
   assign tick     = auto_s && (pre_cnt == SCAN_LAST);
   assign step_evt = step_d && !step_d_q;
   assign adv      = auto_s ? tick : step_evt;

   assign s1 = sel[1];
   assign s0 = sel[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_meta  <= 1'b0;
         step_s     <= 1'b0;
         auto_meta  <= 1'b0;
         auto_s     <= 1'b0;
         deb_cnt    <= '0;
         step_d     <= 1'b0;
         step_d_q   <= 1'b0;
         pre_cnt    <= '0;
         sel        <= 2'd0;
         sample     <= 4'b0000;
         sweep_done <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every right-hand side is the
         // pre-edge value; sample[sel] therefore uses sel from before its increment.
         step_meta <= step;
         step_s    <= step_meta;
         auto_meta <= auto;
         auto_s    <= auto_meta;

         // The new level is accepted on the edge that would make the count reach
         // DEB_CYCLES, which is DEB_CYCLES edges after step_s first differs.
         if (step_s == step_d) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DEB_LAST) begin
            step_d  <= step_s;
            deb_cnt <= '0;
         end else begin
            deb_cnt <= deb_cnt + 1'b1;
         end
         step_d_q <= step_d;

         // Holding at zero in manual mode also covers clearing on every auto_s change.
         if (!auto_s || tick) begin
            pre_cnt <= '0;
         end else begin
            pre_cnt <= pre_cnt + 1'b1;
         end

         sweep_done <= adv && (sel == 2'd3);
         if (adv) begin
            sample[sel] <= m;
            sel         <= sel + 2'd1;
         end
      end
   end

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Self-checking bench for mux_select_sequencer: reset, manual debounce, auto scan,
// mode interaction, sweep snapshots through a scoreboard, and reset mid-sweep.
module tb_mux_select_sequencer;

   localparam int SCAN_DIV   = 4;
   localparam int DEB_CYCLES = 3;

   logic       clk, rst, step, auto, m;
   logic       s1, s0, sweep_done;
   logic [3:0] sample;
   logic [3:0] chan;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;
   logic [3:0] exp_q[$];

   typedef struct {
      logic [3:0] chan;
      logic [1:0] exp_sel;
      logic [3:0] exp_sample;
      bit         push;
   } vec_t;
   vec_t tbl[8];

   // The mux model: m reflects input channel chan[select].
   assign m = chan[{s1, s0}];

   mux_select_sequencer #(.SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB_CYCLES)) dut (
      .clk        (clk),
      .rst        (rst),
      .step       (step),
      .auto       (auto),
      .m          (m),
      .s1         (s1),
      .s0         (s0),
      .sample     (sample),
      .sweep_done (sweep_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic press(input int hold, input int rel);
      step = 1'b1;
      repeat (hold) @(negedge clk);
      step = 1'b0;
      repeat (rel) @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_sel"}, {30'd0, s1, s0}, 32'd0);
      check({tag, "_sample"}, {28'd0, sample}, 32'd0);
      check({tag, "_done"}, {31'd0, sweep_done}, 32'd0);
   endtask

   // Scoreboard: every sweep_done pulse must match a queued snapshot.
   always @(negedge clk) begin
      if (sweep_done === 1'b1) begin
         done_cnt++;
         if (exp_q.size() == 0)
            check("sb_unexpected_done", {31'd0, sweep_done}, 32'd0);
         else
            check("sb_sample", {28'd0, sample}, {28'd0, exp_q.pop_front()});
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int exp_sel;
      int d0;
      tbl[0] = '{4'b1111, 2'd1, 4'b0001, 1'b0};
      tbl[1] = '{4'b1111, 2'd2, 4'b0011, 1'b0};
      tbl[2] = '{4'b1111, 2'd3, 4'b0111, 1'b0};
      tbl[3] = '{4'b1111, 2'd0, 4'b1111, 1'b1};
      tbl[4] = '{4'b0000, 2'd1, 4'b1110, 1'b0};
      tbl[5] = '{4'b0000, 2'd2, 4'b1100, 1'b0};
      tbl[6] = '{4'b0000, 2'd3, 4'b1000, 1'b0};
      tbl[7] = '{4'b0000, 2'd0, 4'b0000, 1'b1};

      rst = 1'b1; step = 1'b0; auto = 1'b0; chan = 4'b0101;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Manual debounce: bounce, then a stable level; advance lands DEB_CYCLES+3 edges in.
      foreach (tbl[i]) if (i < 4) begin
         step = i[0] ? 1'b0 : 1'b1;
         @(negedge clk);
      end
      step = 1'b1;
      repeat (DEB_CYCLES + 2) @(negedge clk);
      check("deb_before_adv", {30'd0, s1, s0}, 32'd0);
      @(negedge clk);
      check("deb_at_adv", {30'd0, s1, s0}, 32'd1);
      repeat (4) @(negedge clk);
      check("deb_held_once", {30'd0, s1, s0}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         step = (i % 2 == 1);
         @(negedge clk);
      end
      step = 1'b0;
      repeat (10) @(negedge clk);
      check("deb_release_none", {30'd0, s1, s0}, 32'd1);
      check("deb_sample", {28'd0, sample}, 32'h1);
      press(8, 8);
      check("man_sel2", {30'd0, s1, s0}, 32'd2);

      // Asynchronous reset in the middle of a cycle.
      #2 rst = 1'b1;
      #1 check_zero("async_rst");
      repeat (3) @(negedge clk);
      check_zero("rst_held");
      rst = 1'b0;

      // Auto scan with a press that must be ignored, then drop to manual at sel=2.
      chan = 4'b1011;
      exp_q.push_back(4'b1011);
      exp_q.push_back(4'b1011);
      auto = 1'b1;
      for (int k = 1; k <= 42; k++) begin
         @(negedge clk);
         exp_sel = (k < 6) ? 0 : (((k - 6) / 4 + 1) % 4);
         check($sformatf("auto_sel_k%0d", k), {30'd0, s1, s0}, exp_sel);
         step = (k >= 21 && k < 31);
      end
      check("auto_sample", {28'd0, sample}, 32'hB);
      check("auto_done_cnt", done_cnt, 2);
      auto = 1'b0;
      for (int j = 1; j <= 8; j++) begin
         @(negedge clk);
         check($sformatf("manual_frozen_%0d", j), {30'd0, s1, s0}, 32'd2);
      end
      check("prescaler_zero", {31'd0, |dut.pre_cnt}, 32'd0);
      press(8, 8);
      check("manual_after_auto", {30'd0, s1, s0}, 32'd3);
      check("manual_after_auto_sample", {28'd0, sample}, 32'hB);

      // Reset at sel=3 one edge before the advance: no sweep_done, restart at 0.
      d0 = done_cnt;
      step = 1'b1;
      repeat (DEB_CYCLES + 2) @(negedge clk);
      check("pre_rst_sel", {30'd0, s1, s0}, 32'd3);
      #2 rst = 1'b1;
      step = 1'b0;
      #1 check_zero("midsweep_rst");
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check_zero("after_midsweep_rst");
      check("midsweep_no_done", done_cnt, d0);

      // Two full manual sweeps with different channel values.
      d0 = done_cnt;
      for (int i = 0; i < 8; i++) begin
         chan = tbl[i].chan;
         if (tbl[i].push) exp_q.push_back(tbl[i].exp_sample);
         press(8, 8);
         check($sformatf("tbl%0d_sel", i), {30'd0, s1, s0}, {30'd0, tbl[i].exp_sel});
         check($sformatf("tbl%0d_sample", i), {28'd0, sample}, {28'd0, tbl[i].exp_sample});
      end
      check("wrap_done_cnt", done_cnt - d0, 2);
      check("sb_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
